// File: rtl/frogger_pkg.sv
// Shared types and PS/2 set-2 scancodes for the frog keyboard front end.
package frogger_pkg;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } ps2_state_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_3     = 8'h26;
    localparam logic [7:0] SC_R     = 8'h2D;

    // Bit i of a direction vector corresponds to dir_t value i; lower index wins.
    function automatic logic [3:0] first_set(input logic [3:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = 4'(1 << i);
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_scancode_parser.sv
// PS/2 prefix FSM: folds E0/F0 prefixes into a single one-cycle make/break event.
module ps2_scancode_parser
    import frogger_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       key_valid,
    input  logic [7:0] key_byte,
    output logic       ev_valid,
    output logic       ev_make,
    output logic       ev_ext,
    output logic [7:0] ev_code
);

    ps2_state_e state_q, state_d;

    always_comb begin
        state_d  = state_q;
        ev_valid = 1'b0;
        ev_make  = 1'b0;
        ev_ext   = 1'b0;
        ev_code  = key_byte;
        if (key_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (key_byte == SC_EXT) begin
                        state_d = StExt;
                    end else if (key_byte == SC_BRK) begin
                        state_d = StBrk;
                    end else begin
                        ev_valid = 1'b1;
                        ev_make  = 1'b1;
                    end
                end
                StExt: begin
                    if (key_byte == SC_BRK) begin
                        state_d = StExtBrk;
                    end else begin
                        ev_valid = 1'b1;
                        ev_make  = 1'b1;
                        ev_ext   = 1'b1;
                        state_d  = StIdle;
                    end
                end
                StBrk: begin
                    ev_valid = 1'b1;
                    state_d  = StIdle;
                end
                StExtBrk: begin
                    ev_valid = 1'b1;
                    ev_ext   = 1'b1;
                    state_d  = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

endmodule

// File: rtl/frog_input_ctrl.sv
// Keyboard-to-frog control: key decode, frog select, typematic suppression, auto-repeat and
// a per-frame move latch.
module frog_input_ctrl
    import frogger_pkg::*;
#(
    parameter int unsigned REPEAT_FRAMES = 0,
    parameter int unsigned CNT_W         = 6
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       key_valid,
    input  logic [7:0] key_byte,
    input  logic       frame_tick,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic       frog_1_key,
    output logic       frog_2_key,
    output logic       frog_3_key,
    output logic       soft_reset_req
);

    localparam int unsigned RptLastI = (REPEAT_FRAMES == 0) ? 0 : REPEAT_FRAMES - 1;
    localparam logic [CNT_W-1:0] RptLast = CNT_W'(RptLastI);

    logic       ev_valid, ev_make, ev_ext;
    logic [7:0] ev_code;

    ps2_scancode_parser u_parser (
        .Clk      (Clk),
        .Reset    (Reset),
        .key_valid(key_valid),
        .key_byte (key_byte),
        .ev_valid (ev_valid),
        .ev_make  (ev_make),
        .ev_ext   (ev_ext),
        .ev_code  (ev_code)
    );

    logic [3:0]       held_q, held_d;
    logic [3:0]       pending_q, pending_d;
    logic [3:0]       dir_out_q, dir_out_d;
    logic [2:0]       sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             soft_q, soft_d;

    logic [3:0] dir_oh, new_move, rpt_move;
    logic [2:0] sel_oh;
    logic       r_hit;

    always_comb begin
        dir_oh = '0;
        sel_oh = '0;
        r_hit  = 1'b0;
        if (ev_valid) begin
            if (ev_ext) begin
                case (ev_code)
                    SC_UP:    dir_oh = 4'b0001;
                    SC_DOWN:  dir_oh = 4'b0010;
                    SC_LEFT:  dir_oh = 4'b0100;
                    SC_RIGHT: dir_oh = 4'b1000;
                    default:  dir_oh = '0;
                endcase
            end else begin
                case (ev_code)
                    SC_W:    dir_oh = 4'b0001;
                    SC_S:    dir_oh = 4'b0010;
                    SC_A:    dir_oh = 4'b0100;
                    SC_D:    dir_oh = 4'b1000;
                    SC_1:    sel_oh = 3'b001;
                    SC_2:    sel_oh = 3'b010;
                    SC_3:    sel_oh = 3'b100;
                    SC_R:    r_hit  = 1'b1;
                    default: dir_oh = '0;
                endcase
            end
        end
    end

    always_comb begin
        held_d   = held_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        new_move = '0;
        rpt_move = '0;
        soft_d   = ev_make & r_hit;

        if (ev_make) begin
            held_d = held_q | dir_oh;
            if (|sel_oh) sel_d = sel_oh;
            // Only a fresh press moves; typematic repeats hit an already-held bit.
            if (|sel_q) new_move = dir_oh & ~held_q;
        end else begin
            held_d = held_q & ~dir_oh;
        end

        if (REPEAT_FRAMES > 0) begin
            if (held_d != held_q) begin
                cnt_d = '0;
            end else if (frame_tick && (|held_q)) begin
                if (cnt_q == RptLast) begin
                    cnt_d = '0;
                    if (|sel_q) rpt_move = first_set(held_q);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // A tick takes the old pending; same-cycle requests land in the cleared set.
        pending_d = (frame_tick ? 4'b0000 : pending_q) | new_move | rpt_move;
        dir_out_d = frame_tick ? first_set(pending_q) : dir_out_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            held_q    <= '0;
            pending_q <= '0;
            dir_out_q <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            soft_q    <= 1'b0;
        end else begin
            held_q    <= held_d;
            pending_q <= pending_d;
            dir_out_q <= dir_out_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            soft_q    <= soft_d;
        end
    end

    assign up             = dir_out_q[DIR_UP];
    assign down           = dir_out_q[DIR_DOWN];
    assign left           = dir_out_q[DIR_LEFT];
    assign right          = dir_out_q[DIR_RIGHT];
    assign frog_1_key     = sel_q[0];
    assign frog_2_key     = sel_q[1];
    assign frog_3_key     = sel_q[2];
    assign soft_reset_req = soft_q;

endmodule

// File: tb/tb_frog_input_ctrl.sv
// Directed bench: one instance without auto-repeat, one with REPEAT_FRAMES=3, shared stimulus.
module tb_frog_input_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_byte = 8'h00;
    logic       frame_tick = 1'b0;

    logic a_up, a_down, a_left, a_right, a_f1, a_f2, a_f3, a_soft;
    logic b_up, b_down, b_left, b_right, b_f1, b_f2, b_f3, b_soft;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    frog_input_ctrl #(.REPEAT_FRAMES(0), .CNT_W(6)) dut0 (
        .Clk(clk), .Reset(rst), .key_valid(key_valid), .key_byte(key_byte),
        .frame_tick(frame_tick), .up(a_up), .down(a_down), .left(a_left), .right(a_right),
        .frog_1_key(a_f1), .frog_2_key(a_f2), .frog_3_key(a_f3), .soft_reset_req(a_soft)
    );

    frog_input_ctrl #(.REPEAT_FRAMES(3), .CNT_W(6)) dut3 (
        .Clk(clk), .Reset(rst), .key_valid(key_valid), .key_byte(key_byte),
        .frame_tick(frame_tick), .up(b_up), .down(b_down), .left(b_left), .right(b_right),
        .frog_1_key(b_f1), .frog_2_key(b_f2), .frog_3_key(b_f3), .soft_reset_req(b_soft)
    );

    wire [3:0] dirs0 = {a_up, a_down, a_left, a_right};
    wire [2:0] sel0  = {a_f1, a_f2, a_f3};

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        key_valid = 1'b1;
        key_byte  = b;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        check_eq("reset_a", {a_up, a_down, a_left, a_right, a_f1, a_f2, a_f3, a_soft}, 8'h00);
        check_eq("reset_b", {b_up, b_down, b_left, b_right, b_f1, b_f2, b_f3, b_soft}, 8'h00);

        // 1: select frog 1, extended up arrow
        send_byte(8'h16);
        check_eq("t1_sel", 8'(sel0), 8'b100);
        send_byte(8'hE0);
        send_byte(8'h75);
        check_eq("t1_pre", 8'(dirs0), 8'b0000);
        tick();
        check_eq("t1_up", 8'(dirs0), 8'b1000);
        repeat (3) @(negedge clk);
        check_eq("t1_hold", 8'(dirs0), 8'b1000);
        tick();
        check_eq("t1_off", 8'(dirs0), 8'b0000);

        // 2: no frog selected -> no move
        do_reset();
        send_byte(8'h1D);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t2_nosel_up", 8'(dirs0), 8'b0000);
        end
        check_eq("t2_nosel", 8'(sel0), 8'b000);
        send_byte(8'hF0);
        send_byte(8'h1D);
        send_byte(8'h1E);
        send_byte(8'h1D);
        check_eq("t2_sel", 8'(sel0), 8'b010);
        tick();
        check_eq("t2_up", 8'(dirs0), 8'b1000);
        tick();
        check_eq("t2_off", 8'(dirs0), 8'b0000);
        send_byte(8'hF0);
        send_byte(8'h1D);
        check_eq("t2_brk_sel", 8'(sel0), 8'b010);

        // 3: typematic suppression
        send_byte(8'h1C);
        send_byte(8'h1C);
        tick();
        check_eq("t3_left", 8'(dirs0), 8'b0010);
        tick();
        check_eq("t3_once", 8'(dirs0), 8'b0000);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'h1C);
        tick();
        check_eq("t3_left2", 8'(dirs0), 8'b0010);
        tick();
        check_eq("t3_off", 8'(dirs0), 8'b0000);
        send_byte(8'hF0);
        send_byte(8'h1C);

        // 4: priority, then key_valid coincident with tick
        send_byte(8'h1B);
        send_byte(8'h23);
        tick();
        check_eq("t4_down", 8'(dirs0), 8'b0100);
        tick();
        check_eq("t4_noright", 8'(dirs0), 8'b0000);
        send_byte(8'hF0);
        send_byte(8'h1B);
        send_byte(8'hF0);
        send_byte(8'h23);
        send_byte(8'hE0);
        @(negedge clk);
        key_valid  = 1'b1;
        key_byte   = 8'h74;
        frame_tick = 1'b1;
        @(negedge clk);
        key_valid  = 1'b0;
        frame_tick = 1'b0;
        check_eq("t4_coinc", 8'(dirs0), 8'b0000);
        tick();
        check_eq("t4_right", 8'(dirs0), 8'b0001);
        tick();
        check_eq("t4_off", 8'(dirs0), 8'b0000);

        // 5: auto-repeat every 3 frames on dut3
        do_reset();
        send_byte(8'h16);
        send_byte(8'h1D);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_eq($sformatf("t5_rpt_%0d", k), 8'(b_up), ((k % 3) == 1) ? 8'd1 : 8'd0);
            check_eq($sformatf("t5_norpt_%0d", k), 8'(a_up), (k == 1) ? 8'd1 : 8'd0);
        end
        send_byte(8'hF0);
        send_byte(8'h1D);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("t5_released", 8'(b_up), 8'd0);
        end

        // 6: reset mid-prefix, then restart key
        do_reset();
        send_byte(8'h16);
        send_byte(8'hE0);
        do_reset();
        send_byte(8'h16);
        check_eq("t6_fresh_sel", 8'(sel0), 8'b100);
        send_byte(8'h75);
        tick();
        check_eq("t6_no_up", 8'(dirs0), 8'b0000);
        @(negedge clk);
        key_valid = 1'b1;
        key_byte  = 8'h2D;
        check_eq("t6_soft_pre", 8'(a_soft), 8'd0);
        @(negedge clk);
        key_valid = 1'b0;
        check_eq("t6_soft_hi", 8'(a_soft), 8'd1);
        @(negedge clk);
        check_eq("t6_soft_lo", 8'(a_soft), 8'd0);
        check_eq("t6_sel_kept", 8'(sel0), 8'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
